mem_dispatcher_write: RTL and testbench
=======================================

MEM_DISPATCHER_WRITE -- requirements
Module: mem_dispatcher_write

Interface
REQ-001 SHALL have parameter FIFO_LENGTH, default 64: max words per MCB write burst, range 1..64.
REQ-002 SHALL have parameter WORDS_TO_WRITE, default 640: 32-bit words written per start.
REQ-003 SHALL have parameter BUFF_ADDR_BITS, default 10: width of line-buffer read address.
REQ-004 SHALL have port clk  in  1: single clock (MCB c3_clk0 domain); all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1: reset, synchronous, active-low.
REQ-006 SHALL have ports os_start in 1 (one-shot start) and init_mem_addr in 30 (start byte address, 4-byte aligned).
REQ-007 SHALL have port busy_write_unit  out  1: high from accepted start until last command issued.
REQ-008 SHALL have ports data_in__re out 1, data_in__addr out BUFF_ADDR_BITS, data_in in 32: line-buffer read, 1-cycle latency.
REQ-009 SHALL have port mem_calib_done  in  1: MCB calibration complete.
REQ-010 SHALL have ports port_cmd_en out 1, port_cmd_instr out 3, port_cmd_bl out 6, port_cmd_byte_addr out 30.
REQ-011 SHALL have ports port_wr_en out 1, port_wr_data out 32, port_wr_full in 1, port_wr_empty in 1.

Function
REQ-012 SHALL implement states IDLE, WAIT_EMPTY, FILL, CMD.
REQ-013 IDLE: os_start=1 and mem_calib_done=1 latches init_mem_addr, words_left=WORDS_TO_WRITE, buffer address 0, go WAIT_EMPTY; os_start with calib low is dropped.
REQ-014 os_start while not IDLE SHALL be ignored, no effect on running transfer.
REQ-015 WAIT_EMPTY: stay until port_wr_empty=1; then burst_len=min(FIFO_LENGTH, words_left), go FILL.
REQ-016 FILL: assert data_in__re with incrementing data_in__addr once per cycle while port_wr_full=0; stop after burst_len reads.
REQ-017 Each read SHALL produce port_wr_en=1, port_wr_data=data_in exactly one cycle after its data_in__re, buffer order preserved.
REQ-018 port_wr_full=1 SHALL pause read issue; in-flight word held in one-entry skid register and written once full drops; no word lost or duplicated.
REQ-019 After burst_len words pushed, go CMD; CMD asserts port_cmd_en for exactly one cycle with instr=3'b000, bl=burst_len-1, byte_addr=current address.
REQ-020 After CMD: address += burst_len*4 (30-bit wrap), words_left -= burst_len; words_left=0 -> IDLE, else WAIT_EMPTY.
REQ-021 data_in__addr SHALL run 0..WORDS_TO_WRITE-1 continuously across bursts, never reset between bursts.
REQ-022 busy_write_unit SHALL fall the cycle after the final port_cmd_en.

Reset
REQ-023 reset_n=0 at any clock edge SHALL force IDLE, counters/address 0, and all outputs 0 next cycle, including mid-FILL or CMD.
REQ-024 Partially filled MCB FIFO after reset SHALL not be flushed by this block; reset of MCB is owner's responsibility.

Configuration
REQ-025 Macro MEM_DISPATCHER_WRITE_DONE_EN defined: adds output write_done (1 bit) pulsing high one cycle, same cycle busy_write_unit falls, reset value 0.
REQ-026 Macro undefined: write_done port absent; all other behaviour identical.

Verification
REQ-027 Defaults, init_mem_addr=0x100, wr_empty=1, full=0 -> 10 commands, bl=63, addrs 0x100,0x200..0xA00, 640 wr_en pulses, data matches buffer.
REQ-028 WORDS_TO_WRITE=100 -> two commands: bl=63 @ addr A, bl=35 @ A+256; 100 writes total.
REQ-029 port_wr_full high 5 cycles mid-FILL -> no wr_en while full, no lost/duplicate word, burst completes with 64 words.
REQ-030 os_start with mem_calib_done=0, then second os_start during busy -> first dropped, second ignored only while busy; no extra commands.
REQ-031 reset_n low during FILL burst 3 -> next cycle all outputs 0, state IDLE; fresh os_start restarts from address 0 of buffer.
REQ-032 With MEM_DISPATCHER_WRITE_DONE_EN: write_done single pulse coincident with busy_write_unit falling edge.

Source files
------------

// File: rtl/mem_dispatcher_write.sv
// Streams WORDS_TO_WRITE line-buffer words into the MCB write FIFO in bursts of up to FIFO_LENGTH words.
// Optional build macro MEM_DISPATCHER_WRITE_DONE_EN adds a one-cycle write_done pulse at transfer end.
module mem_dispatcher_write #(
   parameter int FIFO_LENGTH    = 64,
   parameter int WORDS_TO_WRITE = 640,
   parameter int BUFF_ADDR_BITS = 10
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      os_start,
   input  logic [29:0]               init_mem_addr,
   output logic                      busy_write_unit,
   output logic                      data_in__re,
   output logic [BUFF_ADDR_BITS-1:0] data_in__addr,
   input  logic [31:0]               data_in,
   input  logic                      mem_calib_done,
   output logic                      port_cmd_en,
   output logic [2:0]                port_cmd_instr,
   output logic [5:0]                port_cmd_bl,
   output logic [29:0]               port_cmd_byte_addr,
   output logic                      port_wr_en,
   output logic [31:0]               port_wr_data,
   input  logic                      port_wr_full,
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
   output logic                      write_done,
`endif
   input  logic                      port_wr_empty
);

   localparam int WL_W = $clog2(WORDS_TO_WRITE + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_EMPTY, S_FILL, S_CMD} state_t;

   state_t                    state, state_nx;
   logic [29:0]               addr_q;
   logic [WL_W-1:0]           words_left;
   logic [6:0]                burst_len;
   logic [6:0]                rd_cnt;
   logic [6:0]                wr_cnt;
   logic [BUFF_ADDR_BITS-1:0] buf_addr;
   logic                      rd_pend;
   logic                      skid_valid;
   logic [31:0]               skid_data;

   logic start_ok, rd_issue, wr_fire, last_wr, last_burst;

   // A read is only issued while the FIFO has room, so at most one word is ever in flight
   // when full rises; that single word lands in the skid register.
   assign start_ok   = os_start & mem_calib_done;
   assign rd_issue   = (state == S_FILL) && (rd_cnt != burst_len) && !port_wr_full;
   assign wr_fire    = (rd_pend | skid_valid) & ~port_wr_full;
   assign last_wr    = (state == S_FILL) && wr_fire && (wr_cnt == burst_len - 7'd1);
   assign last_burst = (32'(words_left) == 32'(burst_len));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:       if (start_ok)      state_nx = S_WAIT_EMPTY;
         S_WAIT_EMPTY: if (port_wr_empty) state_nx = S_FILL;
         S_FILL:       if (last_wr)       state_nx = S_CMD;
         S_CMD:        state_nx = last_burst ? S_IDLE : S_WAIT_EMPTY;
         default:      state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy_write_unit    = (state != S_IDLE);
      data_in__re        = rd_issue;
      data_in__addr      = buf_addr;
      port_cmd_en        = (state == S_CMD);
      port_cmd_instr     = 3'b000;
      port_cmd_bl        = 6'd0;
      port_cmd_byte_addr = 30'd0;
      if (state == S_CMD) begin
         port_cmd_bl        = 6'(burst_len - 7'd1);
         port_cmd_byte_addr = addr_q;
      end
      port_wr_en   = wr_fire;
      port_wr_data = 32'd0;
      if (wr_fire) port_wr_data = skid_valid ? skid_data : data_in;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q     <= 30'd0;
         words_left <= '0;
         burst_len  <= 7'd0;
         rd_cnt     <= 7'd0;
         wr_cnt     <= 7'd0;
         buf_addr   <= '0;
         rd_pend    <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= 32'd0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_pend && port_wr_full) begin
            skid_valid <= 1'b1;
            skid_data  <= data_in;
         end else if (skid_valid && !port_wr_full) begin
            skid_valid <= 1'b0;
         end
         if (rd_issue) begin
            buf_addr <= buf_addr + BUFF_ADDR_BITS'(1);
            rd_cnt   <= rd_cnt + 7'd1;
         end
         if (wr_fire) wr_cnt <= wr_cnt + 7'd1;
         case (state)
            S_IDLE: if (start_ok) begin
               addr_q     <= init_mem_addr;
               words_left <= WL_W'(WORDS_TO_WRITE);
               buf_addr   <= '0;
            end
            S_WAIT_EMPTY: if (port_wr_empty) begin
               if (32'(words_left) >= FIFO_LENGTH) burst_len <= 7'(FIFO_LENGTH);
               else                                burst_len <= 7'(words_left);
               rd_cnt <= 7'd0;
               wr_cnt <= 7'd0;
            end
            S_CMD: begin
               addr_q     <= addr_q + {21'd0, burst_len, 2'b00};
               words_left <= words_left - WL_W'(burst_len);
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_DISPATCHER_WRITE_DONE_EN
   // Registered so the pulse lines up with the cycle busy_write_unit drops.
   always_ff @(posedge clk) begin
      if (!reset_n) write_done <= 1'b0;
      else          write_done <= (state == S_CMD) && last_burst;
   end
`endif

endmodule

// File: tb/tb_mem_dispatcher_write.sv
// Bench for mem_dispatcher_write: random line buffer, random FIFO back-pressure, scoreboard of
// expected FIFO words and MCB commands derived from the burst-splitting rule.
module tb_mem_dispatcher_write;

   localparam int FL = 64;
   localparam int W  = 160;
   localparam int AB = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          os_start = 1'b0;
   logic [29:0]   init_mem_addr = 30'd0;
   logic          busy_write_unit;
   logic          data_in__re;
   logic [AB-1:0] data_in__addr;
   logic [31:0]   data_in = 32'd0;
   logic          mem_calib_done = 1'b1;
   logic          port_cmd_en;
   logic [2:0]    port_cmd_instr;
   logic [5:0]    port_cmd_bl;
   logic [29:0]   port_cmd_byte_addr;
   logic          port_wr_en;
   logic [31:0]   port_wr_data;
   logic          port_wr_full = 1'b0;
   logic          port_wr_empty = 1'b1;
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
   logic          write_done;
`endif

   mem_dispatcher_write #(.FIFO_LENGTH(FL), .WORDS_TO_WRITE(W), .BUFF_ADDR_BITS(AB)) dut (
      .clk(clk), .reset_n(reset_n), .os_start(os_start), .init_mem_addr(init_mem_addr),
      .busy_write_unit(busy_write_unit), .data_in__re(data_in__re), .data_in__addr(data_in__addr),
      .data_in(data_in), .mem_calib_done(mem_calib_done), .port_cmd_en(port_cmd_en),
      .port_cmd_instr(port_cmd_instr), .port_cmd_bl(port_cmd_bl),
      .port_cmd_byte_addr(port_cmd_byte_addr), .port_wr_en(port_wr_en), .port_wr_data(port_wr_data),
      .port_wr_full(port_wr_full),
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
      .write_done(write_done),
`endif
      .port_wr_empty(port_wr_empty)
   );

   // clock / reset
   always #5 clk = ~clk;

   // line buffer with one-cycle read latency
   logic [31:0] buf_mem [0:(1<<AB)-1];
   always @(posedge clk) if (data_in__re) data_in <= buf_mem[data_in__addr];

   int n_cmp = 0;
   int n_bad = 0;
   int n_cmd_obs = 0;
   int done_cnt = 0;
   logic prev_busy = 1'b0;
   logic [31:0] exp_q[$];
   logic [38:0] exp_cmd_q[$];

   // scoreboard
   always @(negedge clk) begin
      logic [31:0] e;
      logic [38:0] ec;
      if (port_wr_en) begin
         n_cmp++;
         if (port_wr_full) begin
            n_bad++;
            $display("FAIL wr_while_full: wr_en=1 with full=1, required wr_en=0");
         end else if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_extra: got 0x%08h, required no write", port_wr_data);
         end else begin
            e = exp_q.pop_front();
            if (port_wr_data !== e) begin
               n_bad++;
               $display("FAIL wr_data: got 0x%08h, required 0x%08h", port_wr_data, e);
            end
         end
      end
      if (port_cmd_en) begin
         n_cmp++;
         n_cmd_obs++;
         if (exp_cmd_q.size() == 0) begin
            n_bad++;
            $display("FAIL cmd_extra: got bl=%0d addr=0x%08h, required no command", port_cmd_bl, port_cmd_byte_addr);
         end else begin
            ec = exp_cmd_q.pop_front();
            if ({port_cmd_instr, port_cmd_bl, port_cmd_byte_addr} !== ec) begin
               n_bad++;
               $display("FAIL cmd: got instr=%0d bl=%0d addr=0x%08h, required instr=%0d bl=%0d addr=0x%08h",
                        port_cmd_instr, port_cmd_bl, port_cmd_byte_addr, ec[38:36], ec[35:30], ec[29:0]);
            end
         end
      end
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
      if (write_done) begin
         done_cnt++;
         n_cmp++;
         if (busy_write_unit || !prev_busy) begin
            n_bad++;
            $display("FAIL done_align: busy=%0b prev_busy=%0b, required busy=0 prev_busy=1", busy_write_unit, prev_busy);
         end
      end
`endif
      prev_busy = busy_write_unit;
   end

   // reference model: split W words into bursts of at most FL, address advancing 4 bytes per word
   task automatic build_expect(input logic [29:0] a);
      int n;
      logic [29:0] ca;
      exp_q.delete();
      exp_cmd_q.delete();
      for (int i = 0; i < W; i++) exp_q.push_back(buf_mem[i]);
      for (int off = 0; off < W; off += FL) begin
         n  = (W - off < FL) ? (W - off) : FL;
         ca = a + 30'(off * 4);
         exp_cmd_q.push_back({3'b000, 6'(n - 1), ca});
      end
   endtask

   // driver: mode 0 clean, 1 random back-pressure, 2 five-cycle full burst, 3 extra start while busy
   task automatic run_xfer(input logic [29:0] a, input int mode, output bit saw_busy, output bit timed_out);
      int cyc = 0;
      @(posedge clk); #1;
      init_mem_addr = a;
      os_start = 1'b1;
      @(posedge clk); #1;
      os_start = 1'b0;
      saw_busy = busy_write_unit;
      while (busy_write_unit && cyc < 20000) begin
         case (mode)
            1: begin
               port_wr_full  = ($urandom_range(0, 3) == 0);
               port_wr_empty = ($urandom_range(0, 2) != 0);
            end
            2: port_wr_full = (cyc >= 20 && cyc < 25);
            3: begin
               os_start = (cyc == 30);
               if (cyc == 30) init_mem_addr = 30'h0ABC_0000;
            end
            default: begin
               port_wr_full  = 1'b0;
               port_wr_empty = 1'b1;
            end
         endcase
         @(posedge clk); #1;
         cyc++;
      end
      os_start      = 1'b0;
      port_wr_full  = 1'b0;
      port_wr_empty = 1'b1;
      timed_out     = busy_write_unit;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string name);
      n_cmp++;
      if ({busy_write_unit, data_in__re, data_in__addr, port_cmd_en, port_cmd_instr, port_cmd_bl,
           port_cmd_byte_addr, port_wr_en, port_wr_data} !== '0) begin
         n_bad++;
         $display("FAIL %s: busy=%0b re=%0b raddr=%0d cmd_en=%0b bl=%0d caddr=0x%h wr_en=%0b wr_data=0x%h, required all 0",
                  name, busy_write_unit, data_in__re, data_in__addr, port_cmd_en, port_cmd_bl,
                  port_cmd_byte_addr, port_wr_en, port_wr_data);
      end
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
      n_cmp++;
      if (write_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done: got %0b, required 0", name, write_done);
      end
`endif
   endtask

   task automatic test_transfer(input string name, input logic [29:0] a, input int mode);
      bit sb, to;
      build_expect(a);
      done_cnt = 0;
      run_xfer(a, mode, sb, to);
      n_cmp++;
      if (!sb || to) begin
         n_bad++;
         $display("FAIL %s_busy: saw_busy=%0b timed_out=%0b, required 1/0", name, sb, to);
      end
      n_cmp++;
      if (exp_q.size() != 0 || exp_cmd_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_missing: words_left=%0d cmds_left=%0d, required 0/0", name, exp_q.size(), exp_cmd_q.size());
      end
`ifdef MEM_DISPATCHER_WRITE_DONE_EN
      n_cmp++;
      if (done_cnt != 1) begin
         n_bad++;
         $display("FAIL %s_done_cnt: got %0d, required 1", name, done_cnt);
      end
`endif
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      #1 reset_n = 1'b1;
   endtask

   task automatic test_calib_drop();
      bit busy_seen = 1'b0;
      exp_q.delete();
      exp_cmd_q.delete();
      mem_calib_done = 1'b0;
      @(posedge clk); #1 os_start = 1'b1;
      @(posedge clk); #1 os_start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         busy_seen |= busy_write_unit;
      end
      mem_calib_done = 1'b1;
      n_cmp++;
      if (busy_seen) begin
         n_bad++;
         $display("FAIL calib_drop: busy=1, required 0");
      end
   endtask

   task automatic test_start_ignored();
      test_transfer("start_ignored", 30'h0000_2000, 3);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy_write_unit !== 1'b0) begin
         n_bad++;
         $display("FAIL start_ignored_idle: busy=%0b, required 0", busy_write_unit);
      end
   endtask

   task automatic test_reset_mid_fill();
      int guard = 0;
      build_expect(30'h0000_0040);
      n_cmd_obs = 0;
      @(posedge clk); #1 init_mem_addr = 30'h0000_0040; os_start = 1'b1;
      @(posedge clk); #1 os_start = 1'b0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(n_cmd_obs == 2 && data_in__re) && guard < 2000);
      n_cmp++;
      if (guard >= 2000) begin
         n_bad++;
         $display("FAIL reset_mid_reach: third burst not reached, cmds=%0d required 2", n_cmd_obs);
      end
      reset_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("reset_mid_fill");
      reset_n = 1'b1;
      exp_q.delete();
      exp_cmd_q.delete();
      test_transfer("after_reset", 30'h0000_0000, 0);
   endtask

   initial begin
      logic [31:0] r;
      logic [29:0] ra;
      for (int i = 0; i < (1 << AB); i++) buf_mem[i] = $urandom();
      test_reset();
      test_calib_drop();
      test_transfer("basic", 30'h0000_0100, 0);
      test_transfer("full_pause", 30'h0000_0400, 2);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < W; i++) buf_mem[i] = $urandom();
         r  = $urandom();
         ra = r[29:0];
         ra[1:0] = 2'b00;
         test_transfer("random_stall", ra, 1);
      end
      test_transfer("addr_wrap", 30'h3FFF_FF80, 1);
      test_start_ignored();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
